// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between a UART and a combinational ALU.
// Collects A, B, OPCODE bytes, launches the ALU result back out.
module uart_alu_sequencer #(
    parameter int LEN_DATA       = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic [LEN_DATA-1:0] rx_data_in,
    input  logic                tx_done_tick,
    input  logic [LEN_DATA-1:0] alu_data_in,
    output logic [LEN_DATA-1:0] A,
    output logic [LEN_DATA-1:0] B,
    output logic [5:0]          OPCODE,
    output logic [LEN_DATA-1:0] data_out,
    output logic                tx_start,
    output logic                busy,
    output logic                frame_error,
    output logic                timeout
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_DATA-1:0] a_q, a_d;
    logic [LEN_DATA-1:0] b_q, b_d;
    logic [5:0]          op_q, op_d;
    logic [LEN_DATA-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                ferr_q, ferr_d;
    logic                tout_q, tout_d;
    logic                op_bad;
    logic                cnt_full;

    assign op_bad   = |rx_data_in[LEN_DATA-1:6];
    assign cnt_full = (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        dout_d     = dout_q;
        cnt_d      = '0;
        tx_start_d = 1'b0;
        ferr_d     = 1'b0;
        tout_d     = 1'b0;
        unique case (state_q)
            WAIT_A: begin
                if (rx_done_tick) begin
                    a_d     = rx_data_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the last allowed cycle beats the timeout
                if (rx_done_tick) begin
                    b_d     = rx_data_in;
                    state_d = WAIT_OP;
                end else if (cnt_full) begin
                    tout_d  = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    if (op_bad) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_A;
                    end else begin
                        op_d    = rx_data_in[5:0];
                        state_d = EXEC;
                    end
                end else if (cnt_full) begin
                    tout_d  = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                dout_d  = alu_data_in;
                state_d = SEND;
            end
            SEND: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
        busy_d = (state_d != WAIT_A);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            dout_q     <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
            tout_q     <= tout_d;
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign OPCODE      = op_q;
    assign data_out    = dout_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign frame_error = ferr_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer with a small
// frame-level reference model and a behavioural ALU.
module tb_uart_alu_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_data_in;
    logic [7:0] A, B, data_out;
    logic [5:0] OPCODE;
    logic       tx_start, busy, frame_error, timeout;

    int total = 0;
    int bad   = 0;

    int n_tx = 0;
    int n_fe = 0;
    int n_to = 0;

    logic [7:0] m_a, m_b, m_dout;
    logic [5:0] m_op;

    uart_alu_sequencer #(
        .LEN_DATA(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_done_tick(rx_done_tick),
        .rx_data_in(rx_data_in),
        .tx_done_tick(tx_done_tick),
        .alu_data_in(alu_data_in),
        .A(A),
        .B(B),
        .OPCODE(OPCODE),
        .data_out(data_out),
        .tx_start(tx_start),
        .busy(busy),
        .frame_error(frame_error),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [5:0] op
    );
        if (op == 6'h20) return a + b;
        return (a ^ b) + {2'b00, op};
    endfunction

    assign alu_data_in = alu_ref(A, B, OPCODE);

    always @(negedge clk) begin
        if (tx_start === 1'b1) n_tx++;
        if (frame_error === 1'b1) n_fe++;
        if (timeout === 1'b1) n_to++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_in   = b;
        rx_done_tick = 1'b1;
        cyc();
        rx_done_tick = 1'b0;
        rx_data_in   = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        m_a = 8'h00;
        m_b = 8'h00;
        m_op = 6'h00;
        m_dout = 8'h00;
    endtask

    task automatic test_reset();
        rx_done_tick = 1'b1;
        rx_data_in = 8'h5A;
        tx_done_tick = 1'b1;
        reset = 1'b0;
        cyc();
        cyc();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        total++;
        if ({A, B, OPCODE, data_out} !== 30'h0) begin
            bad++;
            $display("FAIL reset_regs: got %h %h %h %h want 0",
                A, B, OPCODE, data_out);
        end
        total++;
        if ({tx_start, busy, frame_error, timeout} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000",
                {tx_start, busy, frame_error, timeout});
        end
        do_reset();
    endtask

    // Full frame against the model; bad opcodes expect a frame error.
    task automatic run_frame(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] op,
        input int g1,
        input int g2,
        input bit noise
    );
        int tx0, fe0, pos, pulses;
        tx0 = n_tx;
        fe0 = n_fe;
        send_byte(a);
        m_a = a;
        idle(g1);
        send_byte(b);
        m_b = b;
        idle(g2);
        send_byte(op);
        total++;
        if ({A, B} !== {m_a, m_b}) begin
            bad++;
            $display("FAIL frame_ab: got %h %h want %h %h",
                A, B, m_a, m_b);
        end
        if (op[7:6] != 2'b00) begin
            total++;
            if ({frame_error, busy, OPCODE} !== {1'b1, 1'b0, m_op}) begin
                bad++;
                $display("FAIL bad_op: got fe=%b busy=%b op=%h want 1 0 %h",
                    frame_error, busy, OPCODE, m_op);
            end
            idle(4);
            total++;
            if (n_tx != tx0 || n_fe != fe0 + 1) begin
                bad++;
                $display("FAIL bad_op_pulses: got tx=%0d fe=%0d want 0 1",
                    n_tx - tx0, n_fe - fe0);
            end
            return;
        end
        m_op = op[5:0];
        m_dout = alu_ref(m_a, m_b, m_op);
        total++;
        if ({OPCODE, busy, tx_start} !== {m_op, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL op_capture: got %h busy=%b txs=%b want %h 1 0",
                OPCODE, busy, tx_start, m_op);
        end
        pos = -1;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            rx_done_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_data_in = 8'($urandom);
            cyc();
            if (tx_start === 1'b1) begin
                pulses++;
                pos = i;
            end
        end
        rx_done_tick = 1'b0;
        total++;
        if (pulses != 1 || pos != 2) begin
            bad++;
            $display("FAIL tx_start: got pulses=%0d at=%0d want 1 at 2",
                pulses, pos);
        end
        total++;
        if ({A, B, OPCODE, data_out, busy} !==
            {m_a, m_b, m_op, m_dout, 1'b1}) begin
            bad++;
            $display("FAIL hold: got %h %h %h %h %b want %h %h %h %h 1",
                A, B, OPCODE, data_out, busy, m_a, m_b, m_op, m_dout);
        end
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL tx_done: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_normal();
        do_reset();
        run_frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0);
        total++;
        if (data_out !== 8'h08) begin
            bad++;
            $display("FAIL normal_result: got %h want 08", data_out);
        end
    endtask

    task automatic test_bad_opcode();
        do_reset();
        run_frame(8'h01, 8'h02, 8'hC4, 0, 0, 1'b0);
        total++;
        if ({OPCODE, busy, frame_error} !== 8'h00) begin
            bad++;
            $display("FAIL bad_op_after: got %h %b %b want 00 0 0",
                OPCODE, busy, frame_error);
        end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        send_byte(8'h11);
        early = 0;
        for (int i = 1; i < TO; i++) begin
            cyc();
            if (timeout !== 1'b0 || busy !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL timeout_early: got %0d bad cycles want 0", early);
        end
        cyc();
        total++;
        if ({timeout, busy, A, B} !== {1'b1, 1'b0, 8'h11, 8'h00}) begin
            bad++;
            $display("FAIL timeout_fire: got to=%b busy=%b A=%h B=%h want 1 0 11 00",
                timeout, busy, A, B);
        end
        cyc();
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width: got %b want 0", timeout);
        end
        send_byte(8'h22);
        total++;
        if ({A, busy} !== {8'h22, 1'b1}) begin
            bad++;
            $display("FAIL timeout_next_a: got %h %b want 22 1", A, busy);
        end
        send_byte(8'h33);
        idle(TO);
        total++;
        if ({timeout, busy, A, B} !== {1'b1, 1'b0, 8'h22, 8'h33}) begin
            bad++;
            $display("FAIL timeout_op: got to=%b busy=%b A=%h B=%h want 1 0 22 33",
                timeout, busy, A, B);
        end
    endtask

    task automatic test_boundary();
        int to0;
        do_reset();
        to0 = n_to;
        send_byte(8'h40);
        idle(TO - 1);
        send_byte(8'h0A);
        total++;
        if ({B, busy, timeout} !== {8'h0A, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL boundary_b: got B=%h busy=%b to=%b want 0a 1 0",
                B, busy, timeout);
        end
        idle(TO - 1);
        send_byte(8'h07);
        total++;
        if ({OPCODE, busy} !== {6'h07, 1'b1}) begin
            bad++;
            $display("FAIL boundary_op: got %h %b want 07 1", OPCODE, busy);
        end
        idle(4);
        total++;
        if (n_to != to0 || data_out !== alu_ref(8'h40, 8'h0A, 6'h07)) begin
            bad++;
            $display("FAIL boundary_done: got to=%0d dout=%h want 0 %h",
                n_to - to0, data_out, alu_ref(8'h40, 8'h0A, 6'h07));
        end
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
    endtask

    task automatic test_busy_drop();
        do_reset();
        send_byte(8'h10);
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        total++;
        if ({busy, B} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL stray_tx_done: got busy=%b B=%h want 1 00", busy, B);
        end
        send_byte(8'h20);
        send_byte(8'h01);
        idle(3);
        rx_data_in = 8'h99;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        cyc();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        total++;
        if ({A, busy} !== {8'h10, 1'b0}) begin
            bad++;
            $display("FAIL busy_drop: got A=%h busy=%b want 10 0", A, busy);
        end
        cyc();
        total++;
        if ({A, busy} !== {8'h10, 1'b0}) begin
            bad++;
            $display("FAIL busy_drop_after: got A=%h busy=%b want 10 0",
                A, busy);
        end
    endtask

    task automatic test_mid_reset();
        int tx0;
        do_reset();
        send_byte(8'h7F);
        send_byte(8'h01);
        tx0 = n_tx;
        rx_data_in = 8'h05;
        rx_done_tick = 1'b1;
        reset = 1'b0;
        cyc();
        rx_done_tick = 1'b0;
        reset = 1'b1;
        total++;
        if ({A, B, OPCODE, data_out, tx_start, busy, frame_error, timeout}
            !== 34'h0) begin
            bad++;
            $display("FAIL mid_reset: got %h %h %h %h %b%b%b%b want all 0",
                A, B, OPCODE, data_out, tx_start, busy, frame_error, timeout);
        end
        idle(6);
        total++;
        if (n_tx != tx0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_quiet: got tx=%0d busy=%b want 0 0",
                n_tx - tx0, busy);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] a, b, op;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = {2'b00, 6'($urandom)};
            if ($urandom_range(0, 3) == 0)
                op[7:6] = 2'($urandom_range(1, 3));
            run_frame(a, b, op, $urandom_range(0, 8),
                $urandom_range(0, 8), 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_bad_opcode();
        test_timeout();
        test_boundary();
        test_busy_drop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
